// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: program-counter load, instruction-memory read and decoder handshake.
// master is the fetch unit's view; slave is the surrounding PC/memory/decoder view.
interface fetch_unit_if #(
  parameter int unsigned INSTR_W = 16
);
  logic [7:0]         pc_adrs;
  logic [7:0]         next_adrs;
  logic               en_pc;
  logic               mem_req;
  logic [7:0]         mem_adrs;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [7:0]         branch_target;

  modport master (
    input  pc_adrs, mem_ack, mem_data, instr_ready, branch_taken, branch_target,
    output next_adrs, en_pc, mem_req, mem_adrs, instr, instr_valid
  );

  modport slave (
    output pc_adrs, mem_ack, mem_data, instr_ready, branch_taken, branch_target,
    input  next_adrs, en_pc, mem_req, mem_adrs, instr, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: request at PC, hold the word for the decoder,
// then strobe the next (sequential or branch) address into the program counter.
module fetch_unit #(
  parameter int unsigned INSTR_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c_e,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [7:0]         mem_adrs_q, mem_adrs_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [7:0]         next_adrs_q, next_adrs_d;
  logic               en_pc_q, en_pc_d;

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_adrs_d    = mem_adrs_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    next_adrs_d   = next_adrs_q;
    en_pc_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (c_e) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_adrs_d = bus.pc_adrs;
        end
      end
      // Memory data is captured regardless of c_e so a returning read is never lost.
      REQ: begin
        if (bus.mem_ack) begin
          state_d       = HOLD;
          mem_req_d     = 1'b0;
          instr_d       = bus.mem_data;
          instr_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (instr_valid_q && bus.instr_ready && c_e) begin
          state_d       = UPD;
          instr_valid_d = 1'b0;
          next_adrs_d   = bus.branch_taken ? bus.branch_target : bus.pc_adrs + 8'd1;
          en_pc_d       = 1'b1;
        end
      end
      // UPD always returns to IDLE so the PC strobe lasts exactly one cycle.
      UPD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_adrs_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      next_adrs_q   <= '0;
      en_pc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_adrs_q    <= mem_adrs_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      next_adrs_q   <= next_adrs_d;
      en_pc_q       <= en_pc_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_adrs    = mem_adrs_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.next_adrs   = next_adrs_q;
  assign bus.en_pc       = en_pc_q;

endmodule
